// File: rtl/mips_regfile_sb_pkg.sv
// mips_rf_pkg: shared constants and types for the Decode-stage register file
// with its pending-write scoreboard.
//   ZERO_REG      architectural register hardwired to zero
//   DEF_*         default configuration of mips_regfile_sb
//   reg_addr_t    register address type for the default 32-register config
package mips_rf_pkg;

   localparam int DEF_WIDTH    = 32;
   localparam int DEF_NREGS    = 32;
   localparam int DEF_NUM_READ = 2;
   localparam int DEF_PEND_W   = 2;

   typedef logic [4:0] reg_addr_t;

   localparam reg_addr_t ZERO_REG = 5'd0;

endpackage

// File: rtl/mips_regfile_sb_counter.sv
// sb_counter: per-register count of writes in flight.
// Saturating PEND_W-bit up/down counter with synchronous reset.
//   clk    in   clock, state on posedge
//   reset  in   synchronous, active-high
//   inc    in   an accepted issue targets this register
//   dec    in   a writeback targets this register (ignored when count is 0)
//   cnt    out  current pending count (registered)
//   uflow  out  writeback arrived while nothing was pending (combinational)
module sb_counter
   import mips_rf_pkg::*;
#(
   parameter int PEND_W = DEF_PEND_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              inc,
   input  logic              dec,
   output logic [PEND_W-1:0] cnt,
   output logic              uflow
);

   localparam logic [PEND_W-1:0] CNT_ZERO = PEND_W'(0);
   localparam logic [PEND_W-1:0] CNT_ONE  = PEND_W'(1);
   localparam logic [PEND_W-1:0] CNT_MAX  = PEND_W'((2 ** PEND_W) - 1);

   logic [PEND_W-1:0] cnt_r;
   logic              inc_ok_s;
   logic              dec_ok_s;

   // A decrement only counts when something is outstanding; an increment at
   // saturation is only legal when a decrement frees a slot the same cycle.
   assign dec_ok_s = dec && (cnt_r != CNT_ZERO);
   assign inc_ok_s = inc && ((cnt_r != CNT_MAX) || dec_ok_s);
   assign uflow    = dec && (cnt_r == CNT_ZERO);
   assign cnt      = cnt_r;

   // Pending-count state: inc and dec together leave the count unchanged.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_r <= CNT_ZERO;
      end else begin
         case ({inc_ok_s, dec_ok_s})
            2'b10:   cnt_r <= cnt_r + CNT_ONE;
            2'b01:   cnt_r <= cnt_r - CNT_ONE;
            default: cnt_r <= cnt_r;
         endcase
      end
   end

endmodule

// File: rtl/mips_regfile_sb.sv
// mips_regfile_sb: MIPS register file with write-through bypass and a
// pending-write scoreboard for the Decode stage.
//   clk           in   single clock, all state on posedge
//   reset         in   synchronous, active-high
//   ra            in   NUM_READ read addresses
//   rd            out  NUM_READ read data (combinational, bypassed from wb)
//   rd_busy       out  per read port: register still has a pending write
//   iss_valid     in   an instruction writing iss_rd issues this cycle
//   iss_rd        in   destination of the issuing instruction
//   iss_ready     out  issue accepted (combinational)
//   wb_en         in   writeback this cycle
//   wb_addr       in   writeback destination
//   wb_data       in   writeback data
//   idle          out  no writes pending on any register
//   err_underflow out  sticky: writeback to a register with nothing pending
module mips_regfile_sb
   import mips_rf_pkg::*;
#(
   parameter int WIDTH    = DEF_WIDTH,
   parameter int NREGS    = DEF_NREGS,
   parameter int NUM_READ = DEF_NUM_READ,
   parameter int PEND_W   = DEF_PEND_W,
   localparam int ADDR_W  = $clog2(NREGS)
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic [NUM_READ-1:0][ADDR_W-1:0]    ra,
   output logic [NUM_READ-1:0][WIDTH-1:0]     rd,
   output logic [NUM_READ-1:0]                rd_busy,
   input  logic                               iss_valid,
   input  logic [ADDR_W-1:0]                  iss_rd,
   output logic                               iss_ready,
   input  logic                               wb_en,
   input  logic [ADDR_W-1:0]                  wb_addr,
   input  logic [WIDTH-1:0]                   wb_data,
   output logic                               idle,
   output logic                               err_underflow
);

   localparam int                PEND_MAX = (2 ** PEND_W) - 1;
   localparam logic [ADDR_W-1:0] ZERO_A   = ADDR_W'(ZERO_REG);
   localparam logic [PEND_W-1:0] CNT_ZERO = PEND_W'(0);
   localparam logic [PEND_W-1:0] CNT_MAX  = PEND_W'(PEND_MAX);

   logic [WIDTH-1:0]               regs_r [NREGS];
   logic [NREGS-1:0][PEND_W-1:0]   cnt_s;
   logic [NREGS-1:1]               inc_s;
   logic [NREGS-1:1]               dec_s;
   logic [NREGS-1:1]               uflow_s;
   logic [NUM_READ-1:0]            hit_s;
   logic                           iss_ready_s;
   logic                           err_r;

   // Register 0 never has anything pending, so it gets no counter.
   assign cnt_s[0] = CNT_ZERO;

   // A saturated destination can still accept an issue when its writeback
   // retires in the same cycle.
   assign iss_ready_s = (iss_rd == ZERO_A)
                     || (cnt_s[iss_rd] != CNT_MAX)
                     || (wb_en && (wb_addr == iss_rd));
   assign iss_ready   = iss_ready_s;

   genvar g;
   generate
      for (g = 1; g < NREGS; g++) begin : g_cnt
         assign inc_s[g] = iss_valid && iss_ready_s && (iss_rd == ADDR_W'(g));
         assign dec_s[g] = wb_en && (wb_addr == ADDR_W'(g));

         sb_counter #(.PEND_W(PEND_W)) u_cnt (
            .clk   (clk),
            .reset (reset),
            .inc   (inc_s[g]),
            .dec   (dec_s[g]),
            .cnt   (cnt_s[g]),
            .uflow (uflow_s[g])
         );
      end
   endgenerate

   assign idle          = (cnt_s == '0);
   assign err_underflow = err_r;

   // Read ports: bypass the writeback data, and let busy drop in the same
   // cycle as the last outstanding writeback for that register.
   always_comb begin
      rd      = '0;
      rd_busy = '0;
      hit_s   = '0;
      for (int i = 0; i < NUM_READ; i++) begin
         if (ra[i] == ZERO_A) begin
            rd[i]      = '0;
            rd_busy[i] = 1'b0;
         end else begin
            hit_s[i]   = wb_en && (wb_addr == ra[i]) && (cnt_s[ra[i]] != CNT_ZERO);
            rd_busy[i] = (cnt_s[ra[i]] - PEND_W'(hit_s[i])) != CNT_ZERO;
            if (wb_en && (wb_addr == ra[i])) begin
               rd[i] = wb_data;
            end else begin
               rd[i] = regs_r[ra[i]];
            end
         end
      end
   end

   // Architectural register storage; writes to register 0 are dropped.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k < NREGS; k++) begin
            regs_r[k] <= '0;
         end
      end else if (wb_en && (wb_addr != ZERO_A)) begin
         regs_r[wb_addr] <= wb_data;
      end
   end

   // Sticky underflow flag, cleared only by reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         err_r <= 1'b0;
      end else if (|uflow_s) begin
         err_r <= 1'b1;
      end else begin
         err_r <= err_r;
      end
   end

endmodule

// File: tb/tb_mips_regfile_sb.sv
// tb_mips_regfile_sb: directed scenarios plus a constrained-random phase,
// with expected values queued at stimulus time and compared at negedge.
module tb_mips_regfile_sb;

   logic             clk = 1'b0;
   logic             reset;
   logic [1:0][4:0]  ra;
   logic [1:0][31:0] rd;
   logic [1:0]       rd_busy;
   logic             iss_valid;
   logic [4:0]       iss_rd;
   logic             iss_ready;
   logic             wb_en;
   logic [4:0]       wb_addr;
   logic [31:0]      wb_data;
   logic             idle;
   logic             err_underflow;

   int vectors     = 0;
   int miscompares = 0;

   string       tag_q [$];
   int          sel_q [$];
   logic [31:0] exp_q [$];

   // reference model state
   logic [31:0] m_regs [32];
   logic [1:0]  m_cnt  [32];
   logic        m_err;
   logic        e_ready;
   logic        e_idle;

   localparam int S_RD0 = 0, S_RD1 = 1, S_BUSY0 = 2, S_BUSY1 = 3,
                  S_READY = 4, S_IDLE = 5, S_ERR = 6;

   always #5 clk = ~clk;

   mips_regfile_sb dut (
      .clk           (clk),
      .reset         (reset),
      .ra            (ra),
      .rd            (rd),
      .rd_busy       (rd_busy),
      .iss_valid     (iss_valid),
      .iss_rd        (iss_rd),
      .iss_ready     (iss_ready),
      .wb_en         (wb_en),
      .wb_addr       (wb_addr),
      .wb_data       (wb_data),
      .idle          (idle),
      .err_underflow (err_underflow)
   );

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] observe(input int sel);
      case (sel)
         S_RD0:   return rd[0];
         S_RD1:   return rd[1];
         S_BUSY0: return {31'd0, rd_busy[0]};
         S_BUSY1: return {31'd0, rd_busy[1]};
         S_READY: return {31'd0, iss_ready};
         S_IDLE:  return {31'd0, idle};
         S_ERR:   return {31'd0, err_underflow};
         default: return 32'hDEAD_BEEF;
      endcase
   endfunction

   task automatic push(input string tag, input int sel, input logic [31:0] e);
      tag_q.push_back(tag);
      sel_q.push_back(sel);
      exp_q.push_back(e);
   endtask

   // compare everything queued for this cycle at negedge, then cross a posedge
   task automatic cycle();
      @(negedge clk);
      while (sel_q.size() > 0) begin
         check_val(tag_q.pop_front(), observe(sel_q.pop_front()), exp_q.pop_front());
      end
      @(posedge clk);
      #1;
   endtask

   task automatic quiet();
      iss_valid = 1'b0;
      wb_en     = 1'b0;
      iss_rd    = 5'd0;
      wb_addr   = 5'd0;
      wb_data   = 32'd0;
   endtask

   initial begin
      quiet();
      ra    = '0;
      reset = 1'b1;
      cycle();
      reset = 1'b0;

      // 1: reset state
      ra[0] = 5'd3; ra[1] = 5'd0; iss_rd = 5'd3;
      push("rst_rd0", S_RD0, 32'd0);
      push("rst_rd1", S_RD1, 32'd0);
      push("rst_busy0", S_BUSY0, 32'd0);
      push("rst_busy1", S_BUSY1, 32'd0);
      push("rst_idle", S_IDLE, 32'd1);
      push("rst_ready", S_READY, 32'd1);
      push("rst_err", S_ERR, 32'd0);
      cycle();

      // 2: issue then bypassed writeback
      iss_valid = 1'b1; iss_rd = 5'd3;
      push("t2_iss_ready", S_READY, 32'd1);
      cycle();
      quiet();
      push("t2_pend_busy", S_BUSY0, 32'd1);
      push("t2_pend_idle", S_IDLE, 32'd0);
      cycle();
      wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'd8;
      push("t2_byp_rd0", S_RD0, 32'd8);
      push("t2_byp_busy0", S_BUSY0, 32'd0);
      cycle();
      quiet();
      push("t2_reg3", S_RD0, 32'd8);
      push("t2_idle", S_IDLE, 32'd1);
      cycle();

      // 3: saturate register 5
      ra[0] = 5'd5;
      for (int k = 0; k < 3; k++) begin
         iss_valid = 1'b1; iss_rd = 5'd5;
         push("t3_ready", S_READY, 32'd1);
         cycle();
      end
      push("t3_full_ready", S_READY, 32'd0);
      push("t3_full_busy", S_BUSY0, 32'd1);
      push("t3_full_idle", S_IDLE, 32'd0);
      cycle();
      quiet();
      iss_rd = 5'd5;
      for (int k = 0; k < 3; k++) begin
         wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'd100 + 32'(k);
         push("t3_wb_busy", S_BUSY0, (k < 2) ? 32'd1 : 32'd0);
         push("t3_wb_rd", S_RD0, 32'd100 + 32'(k));
         push("t3_wb_ready", S_READY, 32'd1);
         cycle();
      end
      quiet();
      push("t3_idle", S_IDLE, 32'd1);
      push("t3_busy_end", S_BUSY0, 32'd0);
      push("t3_rd_end", S_RD0, 32'd102);
      cycle();

      // 4: same-cycle issue and writeback on a pending register
      iss_valid = 1'b1; iss_rd = 5'd5;
      cycle();
      wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'h0000_000A;
      push("t4_same_busy", S_BUSY0, 32'd0);
      push("t4_same_rd", S_RD0, 32'h0000_000A);
      push("t4_same_ready", S_READY, 32'd1);
      cycle();
      quiet();
      push("t4_after_busy", S_BUSY0, 32'd1);
      push("t4_after_rd", S_RD0, 32'h0000_000A);
      push("t4_after_idle", S_IDLE, 32'd0);
      cycle();
      wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'h0000_000A;
      cycle();
      quiet();
      push("t4_idle", S_IDLE, 32'd1);
      cycle();

      // 5: register 0 is immune to writes and issues
      ra[0] = 5'd0; ra[1] = 5'd0;
      wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFF_FFFF;
      iss_valid = 1'b1; iss_rd = 5'd0;
      push("t5_rd0", S_RD0, 32'd0);
      push("t5_busy0", S_BUSY0, 32'd0);
      push("t5_ready", S_READY, 32'd1);
      push("t5_idle", S_IDLE, 32'd1);
      cycle();
      quiet();
      push("t5_idle_after", S_IDLE, 32'd1);
      push("t5_err_after", S_ERR, 32'd0);
      push("t5_rd1_after", S_RD1, 32'd0);
      cycle();

      // 6: underflow, stickiness, reset clears
      ra[0] = 5'd7;
      wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'd1;
      push("t6_err_pre", S_ERR, 32'd0);
      cycle();
      quiet();
      for (int k = 0; k < 5; k++) begin
         push("t6_reg7", S_RD0, 32'd1);
         push("t6_err_hold", S_ERR, 32'd1);
         cycle();
      end
      iss_valid = 1'b1; iss_rd = 5'd2;
      cycle();
      cycle();
      quiet();
      ra[0] = 5'd2;
      reset = 1'b1;
      iss_valid = 1'b1; iss_rd = 5'd4;
      wb_en = 1'b1; wb_addr = 5'd9; wb_data = 32'd5;
      push("t6_busy2", S_BUSY0, 32'd1);
      push("t6_idle_pre", S_IDLE, 32'd0);
      push("t6_err_pre_rst", S_ERR, 32'd1);
      cycle();
      reset = 1'b0;
      quiet();
      ra[0] = 5'd9; ra[1] = 5'd4;
      push("t6_rst_err", S_ERR, 32'd0);
      push("t6_rst_idle", S_IDLE, 32'd1);
      push("t6_rst_rd9", S_RD0, 32'd0);
      push("t6_rst_busy4", S_BUSY1, 32'd0);
      cycle();

      // constrained-random phase against the reference model
      for (int r = 0; r < 32; r++) begin
         m_regs[r] = 32'd0;
         m_cnt[r]  = 2'd0;
      end
      m_err = 1'b0;
      for (int n = 0; n < 300; n++) begin
         iss_valid = ($urandom_range(0, 4) < 3);
         iss_rd    = 5'($urandom_range(0, 4));
         wb_en     = ($urandom_range(0, 1) == 1);
         wb_addr   = 5'($urandom_range(0, 4));
         wb_data   = $urandom;
         ra[0]     = 5'($urandom_range(0, 4));
         ra[1]     = 5'($urandom_range(0, 4));

         for (int p = 0; p < 2; p++) begin
            logic [4:0]  a;
            logic [31:0] e_rd;
            logic        hit;
            logic        e_busy;
            a = ra[p];
            if (a == 5'd0) begin
               e_rd   = 32'd0;
               e_busy = 1'b0;
            end else begin
               e_rd   = (wb_en && wb_addr == a) ? wb_data : m_regs[a];
               hit    = wb_en && (wb_addr == a) && (m_cnt[a] != 2'd0);
               e_busy = (m_cnt[a] - {1'b0, hit}) != 2'd0;
            end
            push(p == 0 ? "rnd_rd0" : "rnd_rd1", p == 0 ? S_RD0 : S_RD1, e_rd);
            push(p == 0 ? "rnd_busy0" : "rnd_busy1", p == 0 ? S_BUSY0 : S_BUSY1, {31'd0, e_busy});
         end
         e_ready = (iss_rd == 5'd0) || (m_cnt[iss_rd] != 2'd3) || (wb_en && wb_addr == iss_rd);
         e_idle  = 1'b1;
         for (int r = 1; r < 32; r++) begin
            if (m_cnt[r] != 2'd0) e_idle = 1'b0;
         end
         push("rnd_ready", S_READY, {31'd0, e_ready});
         push("rnd_idle", S_IDLE, {31'd0, e_idle});
         push("rnd_err", S_ERR, {31'd0, m_err});
         cycle();

         if (wb_en && wb_addr != 5'd0 && m_cnt[wb_addr] == 2'd0) m_err = 1'b1;
         for (int r = 1; r < 32; r++) begin
            logic inc;
            logic dec;
            inc = iss_valid && e_ready && (iss_rd == 5'(r));
            dec = wb_en && (wb_addr == 5'(r)) && (m_cnt[r] != 2'd0);
            if (inc && !dec) m_cnt[r] = m_cnt[r] + 2'd1;
            else if (dec && !inc) m_cnt[r] = m_cnt[r] - 2'd1;
         end
         if (wb_en && wb_addr != 5'd0) m_regs[wb_addr] = wb_data;
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
